sample_player: RTL and testbench
================================

SAMPLE_PLAYER -- requirements
Module: sample_player

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 8: bit width of every sample.
REQ-002 Parameter FIFO_AW, default 4: FIFO address width; depth is 2^FIFO_AW entries.
REQ-003 Parameter TICK_DIV, default 2048: clk cycles per sample period, equal to 2^SAMPLE_WIDTH x 2 x pulses-per-sample; legal range 2..65535.
REQ-004 Parameter PRIME_LEVEL, default 8: FIFO fill required before playback starts; legal range 1..2^FIFO_AW.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 wr_data  input  SAMPLE_WIDTH  sample from the recorder/memory side.
REQ-008 wr_valid  input  1  wr_data is valid this cycle.
REQ-009 wr_ready  output  1  FIFO can accept wr_data; a write occurs when wr_valid and wr_ready are both high.
REQ-010 play  input  1  level; high requests playback.
REQ-011 sample  output  SAMPLE_WIDTH  registered sample to the PWM DAC sample input.
REQ-012 sample_strobe  output  1  one-cycle pulse in the cycle sample takes a new value.
REQ-013 underrun  output  1  one-cycle pulse on each tick that finds the FIFO empty.
REQ-014 underrun_cnt  output  8  saturating count of underruns.
REQ-015 fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.
REQ-016 busy  output  1  high in PRIME or PLAY.

Function
REQ-017 FIFO: synchronous write/read; wr_ready = (fifo_level != 2^FIFO_AW); pointers wrap modulo 2^FIFO_AW.
REQ-018 A write attempted while full is refused, even if a pop occurs in the same cycle.
REQ-019 A write and a pop in the same cycle, FIFO neither full nor empty: level unchanged, both complete.
REQ-020 FSM states IDLE, PRIME, PLAY; IDLE after reset.
REQ-021 IDLE->PRIME when play=1; this transition clears underrun_cnt to 0.
REQ-022 PRIME->PLAY when fifo_level >= PRIME_LEVEL and play=1.
REQ-023 PRIME or PLAY -> IDLE in the cycle after play=0 is sampled; FIFO contents are retained, not flushed.
REQ-024 Tick divider: counts 0..TICK_DIV-1 only in PLAY; held at 0 in IDLE and PRIME; the tick is asserted when count = TICK_DIV-1, then count wraps to 0.
REQ-025 First tick occurs TICK_DIV cycles after entering PLAY.
REQ-026 On tick with FIFO non-empty: pop head; sample <= head and sample_strobe=1 on the next cycle (latency 1 clk from tick).
REQ-027 On tick with FIFO empty: no pop, sample holds, no strobe; underrun=1 on the next cycle; underrun_cnt += 1, saturating at 255; FSM stays in PLAY.
REQ-028 A write into an empty FIFO in the same cycle as a tick does not satisfy that tick (the tick counts as an underrun), but the write completes.
REQ-029 On entry to IDLE, sample <= midscale 2^(SAMPLE_WIDTH-1) on the next cycle with sample_strobe=1; no strobe if sample already equals midscale.
REQ-030 play toggling high again while still in IDLE restarts priming with the retained FIFO contents.

Reset
REQ-031 While rst_n=0, all state is cleared asynchronously: FSM=IDLE, pointers=0, divider=0, sample=2^(SAMPLE_WIDTH-1), sample_strobe=0, underrun=0, underrun_cnt=0, fifo_level=0, wr_ready=1, busy=0.
REQ-032 Reset asserted mid-playback discards FIFO contents; the first post-reset clock edge behaves as in IDLE.

Verification
REQ-033 TICK_DIV=4, PRIME_LEVEL=2: write 0x10, 0x20, 0x30, then play=1 -> PRIME, PLAY once level>=2, strobes with sample=0x10, 0x20, 0x30 spaced exactly 4 clks apart.
REQ-034 Fill 16 entries (FIFO_AW=4) -> wr_ready=0, 17th write refused, level stays 16; one pop frees exactly one slot.
REQ-035 PLAY with FIFO drained -> underrun pulses every 4 clks, sample held at last value, underrun_cnt reaches 255 and stays there; next play rising edge from IDLE clears it.
REQ-036 Empty FIFO, wr_valid on the same cycle as the tick -> underrun=1, fifo_level=1 afterwards, the following tick delivers the written value.
REQ-037 play=0 during PLAY with 5 entries queued -> IDLE, sample=0x80 with strobe, fifo_level=5 retained.
REQ-038 rst_n pulsed low mid-PLAY (not clock-aligned) -> outputs take reset values immediately, fifo_level=0.

Source files
------------

// File: rtl/sample_player.sv
// Sample playback engine: a small sample FIFO drained at a fixed tick rate
// into a registered sample output for a PWM DAC, with priming and underrun tracking.
module sample_player #(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned TICK_DIV     = 2048,
  parameter int unsigned PRIME_LEVEL  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SAMPLE_WIDTH-1:0] i_wr_data,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic                    i_play,
  output logic [SAMPLE_WIDTH-1:0] o_sample,
  output logic                    o_sample_strobe,
  output logic                    o_underrun,
  output logic [7:0]              o_underrun_cnt,
  output logic [FIFO_AW:0]        o_fifo_level,
  output logic                    o_busy
);

  localparam int unsigned DEPTH_N = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] PRIME_LVL = (FIFO_AW+1)'(PRIME_LEVEL);
  localparam logic [15:0] DIV_MAX = 16'(TICK_DIV - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MID = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [15:0]             r_div;
  logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH_N];
  logic [FIFO_AW-1:0]      r_wr_ptr;
  logic [FIFO_AW-1:0]      r_rd_ptr;
  logic [FIFO_AW:0]        r_level;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic                    r_strobe;
  logic                    r_underrun;
  logic [7:0]              r_ucnt;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_tick;
  logic                    w_pop;
  logic                    w_stop;
  logic [SAMPLE_WIDTH-1:0] w_head;

  assign w_full  = (r_level == DEPTH);
  assign w_empty = (r_level == '0);
  assign w_push  = i_wr_valid && !w_full;
  // Tick is suppressed on the cycle play drops so the stop edge never races a pop.
  assign w_tick  = (r_state == ST_PLAY) && i_play && (r_div == DIV_MAX);
  // Emptiness is judged on the registered level, so a same-cycle write cannot satisfy the tick.
  assign w_pop   = w_tick && !w_empty;
  assign w_stop  = (r_state != ST_IDLE) && !i_play;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_sample   <= MID;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;

      if (w_pop) begin
        r_sample <= w_head;
        r_strobe <= 1'b1;
      end

      if (w_tick && w_empty) begin
        r_underrun <= 1'b1;
        if (r_ucnt != 8'hFF) begin
          r_ucnt <= r_ucnt + 1'b1;
        end
      end

      if (w_stop && (r_sample != MID)) begin
        r_sample <= MID;
        r_strobe <= 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          r_div <= '0;
          if (i_play) begin
            r_state <= ST_PRIME;
            r_ucnt  <= '0;
          end
        end
        ST_PRIME: begin
          r_div <= '0;
          if (!i_play) begin
            r_state <= ST_IDLE;
          end else if (r_level >= PRIME_LVL) begin
            r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (!i_play) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
          end else if (r_div == DIV_MAX) begin
            r_div <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_div   <= '0;
        end
      endcase
    end
  end

  assign o_wr_ready      = !w_full;
  assign o_sample        = r_sample;
  assign o_sample_strobe = r_strobe;
  assign o_underrun      = r_underrun;
  assign o_underrun_cnt  = r_ucnt;
  assign o_fifo_level    = r_level;
  assign o_busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sample_player.sv
// Scoreboard bench for sample_player: accepted writes queue expected samples,
// each strobe pops and compares; timing and boundary cases are checked directly.
module tb_sample_player;

  localparam int SW = 8;
  localparam int AW = 4;
  localparam int TD = 4;
  localparam int PL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          play;
  logic [SW-1:0] sample;
  logic          sample_strobe;
  logic          underrun;
  logic [7:0]    underrun_cnt;
  logic [AW:0]   fifo_level;
  logic          busy;

  sample_player #(
    .SAMPLE_WIDTH (SW),
    .FIFO_AW      (AW),
    .TICK_DIV     (TD),
    .PRIME_LEVEL  (PL)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_wr_data       (wr_data),
    .i_wr_valid      (wr_valid),
    .o_wr_ready      (wr_ready),
    .i_play          (play),
    .o_sample        (sample),
    .o_sample_strobe (sample_strobe),
    .o_underrun      (underrun),
    .o_underrun_cnt  (underrun_cnt),
    .o_fifo_level    (fifo_level),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          n_under  = 0;
  logic [7:0]  m_fifo[$];
  int          strobe_cyc[$];
  int          under_cyc[$];
  bit          exp_mid  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: account an accepted write, advance, then score the outputs.
  task automatic step();
    if (wr_valid && wr_ready) m_fifo.push_back(wr_data);
    @(posedge clk);
    #1;
    cyc++;
    if (sample_strobe) begin
      strobe_cyc.push_back(cyc);
      if (exp_mid) begin
        check("mid_sample", {24'd0, sample}, 32'h80);
        exp_mid = 1'b0;
      end else if (m_fifo.size() == 0) begin
        check("unexpected_strobe", {24'd0, sample}, 32'hFFFF_FFFF);
      end else begin
        check("sample", {24'd0, sample}, {24'd0, m_fifo.pop_front()});
      end
    end
    if (underrun) begin
      n_under++;
      under_cyc.push_back(cyc);
    end
    check("level", {27'd0, fifo_level}, m_fifo.size());
  endtask

  initial begin
    int c0;
    int ns;
    rst_n    = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;
    play     = 1'b0;
    #12;
    check("rst_sample", {24'd0, sample}, 32'h80);
    check("rst_strobe", {31'd0, sample_strobe}, 0);
    check("rst_underrun", {31'd0, underrun}, 0);
    check("rst_ucnt", {24'd0, underrun_cnt}, 0);
    check("rst_level", {27'd0, fifo_level}, 0);
    check("rst_ready", {31'd0, wr_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    #10;
    rst_n = 1'b1;

    // Three samples, prime, play at exact tick spacing
    wr_valid = 1'b1;
    wr_data = 8'h10; step();
    wr_data = 8'h20; step();
    wr_data = 8'h30; step();
    wr_valid = 1'b0;
    play = 1'b1;
    c0 = cyc;
    step();
    check("busy_prime", {31'd0, busy}, 1);
    for (int i = 0; i < 30 && strobe_cyc.size() < 3; i++) step();
    check("three_strobes", strobe_cyc.size(), 3);
    if (strobe_cyc.size() >= 3) begin
      check("first_latency", strobe_cyc[0] - c0, 6);
      check("spacing_1", strobe_cyc[1] - strobe_cyc[0], TD);
      check("spacing_2", strobe_cyc[2] - strobe_cyc[1], TD);
    end

    // Drained FIFO: underruns every tick, counter saturates
    for (int i = 0; i < 1100; i++) step();
    check("ucnt_sat", {24'd0, underrun_cnt}, 255);
    check("under_beyond_255", {31'd0, n_under > 255}, 1);
    check("sample_held", {24'd0, sample}, 32'h30);
    check("busy_play", {31'd0, busy}, 1);
    ns = under_cyc.size();
    if (ns >= 2) check("under_spacing", under_cyc[ns-1] - under_cyc[ns-2], TD);
    for (int i = 0; i < 8; i++) step();
    check("ucnt_stays", {24'd0, underrun_cnt}, 255);

    // Write into empty FIFO on the tick cycle
    for (int i = 0; i < 8 && !underrun; i++) step();
    check("under_found", {31'd0, underrun}, 1);
    for (int i = 0; i < 3; i++) step();
    wr_valid = 1'b1; wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    check("race_underrun", {31'd0, underrun}, 1);
    check("race_nostrobe", {31'd0, sample_strobe}, 0);
    check("race_level", {27'd0, fifo_level}, 1);
    for (int i = 0; i < 4; i++) step();
    check("race_delivered", {31'd0, sample_strobe}, 1);

    // Stop with five queued
    wr_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wr_data = 8'h61 + 8'(i);
      step();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 20 && m_fifo.size() != 5; i++) step();
    check("five_queued", m_fifo.size(), 5);
    exp_mid = 1'b1;
    play = 1'b0;
    step();
    check("stop_busy", {31'd0, busy}, 0);
    check("stop_mid_strobe", {31'd0, exp_mid}, 0);
    check("stop_level", {27'd0, fifo_level}, 5);

    // Restart from IDLE with retained contents
    play = 1'b1;
    step();
    check("restart_ucnt_clr", {24'd0, underrun_cnt}, 0);
    check("restart_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 40 && m_fifo.size() != 0; i++) step();
    check("drained", m_fifo.size(), 0);

    // Full FIFO, refused write, pop while full
    exp_mid = 1'b1;
    play = 1'b0;
    step();
    check("idle_mid_strobe", {31'd0, exp_mid}, 0);
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'hA0 + 8'(i);
      step();
    end
    check("full_ready", {31'd0, wr_ready}, 0);
    wr_data = 8'hEE;
    step();
    check("full_refused", {27'd0, fifo_level}, 16);
    play = 1'b1;
    for (int i = 0; i < 12 && !sample_strobe; i++) step();
    check("pop_while_full", {31'd0, sample_strobe}, 1);
    check("one_slot_level", {27'd0, fifo_level}, 15);
    check("one_slot_ready", {31'd0, wr_ready}, 1);
    wr_valid = 1'b0;
    step();
    step();

    // Asynchronous reset mid-playback
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_level", {27'd0, fifo_level}, 0);
    check("arst_sample", {24'd0, sample}, 32'h80);
    check("arst_strobe", {31'd0, sample_strobe}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_ready", {31'd0, wr_ready}, 1);
    check("arst_ucnt", {24'd0, underrun_cnt}, 0);
    m_fifo.delete();
    exp_mid = 1'b0;
    play = 1'b0;
    #10;
    rst_n = 1'b1;
    step();
    check("post_rst_busy", {31'd0, busy}, 0);
    check("post_rst_sample", {24'd0, sample}, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
